game_ctl: RTL and testbench

- Match-flow controller for pong; sits directly upstream of the video/display stage.
- Watches ball x position once per frame (timing_tick), detects goals, and keeps both scores.
- Sequences START -> PLAY -> POINT -> END and produces the state and score buses the display consumes.
- Issues a one-cycle ball_reset/serve pulse to the ball-motion logic.

---
 rtl/game_ctl.sv | 132 +++++++++++++
 tb/tb_game_ctl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctl.sv
// Pong match-flow controller: goal detection, scoring, serve sequencing.
module game_ctl #(
  parameter int unsigned LEFT_GOAL_X  = 10,
  parameter int unsigned RIGHT_GOAL_X = 1013,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic [10:0] x_ball,
  output logic [1:0]  state,
  output logic [3:0]  player1_score,
  output logic [3:0]  player2_score,
  output logic        ball_reset,
  output logic        serve_dir,
  output logic        winner
);

  localparam int unsigned CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_p1_score;
  logic [3:0]       r_p2_score;
  logic             r_ball_reset;
  logic             r_serve_dir;
  logic             r_winner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start_q;

  logic w_start_edge;
  logic w_goal_left;
  logic w_goal_right;
  logic w_p1_won;
  logic w_p2_won;
  logic w_pause_done;

  assign w_start_edge = start & ~r_start_q;
  assign w_goal_left  = (x_ball <= 11'(LEFT_GOAL_X));
  assign w_goal_right = (x_ball >= 11'(RIGHT_GOAL_X));
  assign w_p1_won     = (r_p1_score == 4'(WIN_SCORE));
  assign w_p2_won     = (r_p2_score == 4'(WIN_SCORE));
  assign w_pause_done = (r_cnt == CNT_W'(PAUSE_FRAMES - 1));

  // Start button history; reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b1;
    end else begin
      r_start_q <= start;
    end
  end

  // Match state machine with scores, pause counter and serve control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_START;
      r_p1_score   <= 4'd0;
      r_p2_score   <= 4'd0;
      r_ball_reset <= 1'b0;
      r_serve_dir  <= 1'b0;
      r_winner     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_ball_reset <= 1'b0;
      case (r_state)
        S_START: begin
          if (w_start_edge) begin
            r_state      <= S_PLAY;
            r_ball_reset <= 1'b1;
          end
        end
        S_PLAY: begin
          if (timing_tick) begin
            if (w_goal_left) begin
              r_p2_score  <= (r_p2_score < 4'(WIN_SCORE)) ? r_p2_score + 4'd1 : r_p2_score;
              r_serve_dir <= 1'b0;
              r_state     <= S_POINT;
              r_cnt       <= '0;
            end else if (w_goal_right) begin
              r_p1_score  <= (r_p1_score < 4'(WIN_SCORE)) ? r_p1_score + 4'd1 : r_p1_score;
              r_serve_dir <= 1'b1;
              r_state     <= S_POINT;
              r_cnt       <= '0;
            end
          end
        end
        S_POINT: begin
          // Ball position is ignored here so a ball still past the line cannot re-score.
          if (timing_tick) begin
            if (w_p1_won || w_p2_won) begin
              r_state  <= S_END;
              r_winner <= w_p2_won;
              r_cnt    <= r_cnt + CNT_W'(1);
            end else if (w_pause_done) begin
              r_state      <= S_PLAY;
              r_ball_reset <= 1'b1;
              r_cnt        <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_END: begin
          // A new match returns to START; a second press serves.
          if (w_start_edge) begin
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_state    <= S_START;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

  assign state         = r_state;
  assign player1_score = r_p1_score;
  assign player2_score = r_p2_score;
  assign ball_reset    = r_ball_reset;
  assign serve_dir     = r_serve_dir;
  assign winner        = r_winner;

endmodule

// File: tb/tb_game_ctl.sv
// Self-checking bench for game_ctl using a reference model and expectation queue.
module tb_game_ctl;

  logic        clk;
  logic        rst;
  logic        timing_tick;
  logic        start;
  logic [10:0] x_ball;
  logic [1:0]  state;
  logic [3:0]  player1_score;
  logic [3:0]  player2_score;
  logic        ball_reset;
  logic        serve_dir;
  logic        winner;

  game_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .timing_tick  (timing_tick),
    .start        (start),
    .x_ball       (x_ball),
    .state        (state),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .ball_reset   (ball_reset),
    .serve_dir    (serve_dir),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int p1;
    int p2;
    int br;
    int sd;
    int win;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model of the match controller.
  int m_state, m_p1, m_p2, m_br, m_sd, m_win, m_cnt, m_sq;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_p1 = 0; m_p2 = 0; m_br = 0; m_sd = 0; m_win = 0; m_cnt = 0; m_sq = 1;
  endtask

  task automatic model_step(input int st, input int tk, input int x);
    int edge_s;
    edge_s = (st == 1 && m_sq == 0) ? 1 : 0;
    m_sq   = st;
    m_br   = 0;
    if (m_state == 0) begin
      if (edge_s == 1) begin m_state = 1; m_br = 1; end
    end else if (m_state == 1) begin
      if (tk == 1 && x <= 10) begin
        if (m_p2 < 9) m_p2++;
        m_sd = 0; m_state = 2; m_cnt = 0;
      end else if (tk == 1 && x >= 1013) begin
        if (m_p1 < 9) m_p1++;
        m_sd = 1; m_state = 2; m_cnt = 0;
      end
    end else if (m_state == 2) begin
      if (tk == 1) begin
        if (m_p1 == 9 || m_p2 == 9) begin
          m_state = 3; m_win = (m_p2 == 9) ? 1 : 0;
        end else if (m_cnt == 59) begin
          m_state = 1; m_br = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      if (edge_s == 1) begin m_p1 = 0; m_p2 = 0; m_state = 0; end
    end
  endtask

  // Drive one clock of stimulus, queue the expectation, then compare after the edge.
  task automatic cycle(input int st, input int tk, input int x);
    exp_t e;
    start       = st[0];
    timing_tick = tk[0];
    x_ball      = 11'(x);
    model_step(st, tk, x);
    e.st = m_state; e.p1 = m_p1; e.p2 = m_p2; e.br = m_br; e.sd = m_sd; e.win = m_win;
    q_exp.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (q_exp.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = q_exp.pop_front();
      chk("state",      int'(state),         e.st);
      chk("p1_score",   int'(player1_score), e.p1);
      chk("p2_score",   int'(player2_score), e.p2);
      chk("ball_reset", int'(ball_reset),    e.br);
      chk("serve_dir",  int'(serve_dir),     e.sd);
      chk("winner",     int'(winner),        e.win);
    end
  endtask

  task automatic pause_ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 5);
  endtask

  // Score a goal and, unless it is match point, sit out the full pause.
  task automatic goal(input int x);
    cycle(0, 1, x);
    if (m_state == 2 && m_p1 != 9 && m_p2 != 9) pause_ticks(60);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(state),         0);
    chk({tag, "_p1"},    int'(player1_score), 0);
    chk({tag, "_p2"},    int'(player2_score), 0);
    chk({tag, "_br"},    int'(ball_reset),    0);
    chk({tag, "_sd"},    int'(serve_dir),     0);
    chk({tag, "_win"},   int'(winner),        0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; timing_tick = 1'b0; x_ball = 11'd512;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");

    // Release reset with the button held: no match start.
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 0, 512);
    cycle(1, 0, 512);
    chk("held_start_state", int'(state), 0);

    // Fresh press serves.
    cycle(0, 0, 512);
    cycle(1, 0, 512);
    chk("serve_state", int'(state), 1);
    chk("serve_pulse", int'(ball_reset), 1);
    cycle(1, 0, 512);
    chk("serve_pulse_end", int'(ball_reset), 0);

    // Left goal: no effect without a tick, then registers on the tick.
    cycle(0, 0, 5);
    chk("no_tick_state", int'(state), 1);
    cycle(0, 1, 5);
    chk("left_goal_p2", int'(player2_score), 1);
    chk("left_goal_state", int'(state), 2);
    chk("left_goal_dir", int'(serve_dir), 0);
    pause_ticks(60);
    chk("left_pause_done", int'(state), 1);

    // Right goal then exact pause length.
    cycle(0, 1, 1020);
    pause_ticks(59);
    chk("pause59_state", int'(state), 2);
    pause_ticks(1);
    chk("pause60_state", int'(state), 1);
    chk("pause60_pulse", int'(ball_reset), 1);
    chk("pause60_dir", int'(serve_dir), 1);
    chk("pause60_p1", int'(player1_score), 1);
    cycle(0, 0, 512);

    // Goal-line boundaries.
    cycle(0, 1, 11);
    chk("x11_no_goal", int'(state), 1);
    cycle(0, 1, 1012);
    chk("x1012_no_goal", int'(state), 1);
    cycle(0, 1, 10);
    chk("x10_goal_p2", int'(player2_score), 2);
    pause_ticks(60);
    cycle(0, 1, 1013);
    chk("x1013_goal_p1", int'(player1_score), 2);
    pause_ticks(60);

    // Drive player 1 to the winning score.
    for (int g = 0; g < 7; g++) goal(1020);
    chk("match_point_p1", int'(player1_score), 9);
    chk("match_point_state", int'(state), 2);
    cycle(0, 1, 1020);
    chk("end_state", int'(state), 3);
    chk("end_winner", int'(winner), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1020);
    chk("end_hold_p1", int'(player1_score), 9);
    chk("end_hold_state", int'(state), 3);

    // New match: first press returns to START, second serves.
    cycle(1, 0, 512);
    chk("restart_state", int'(state), 0);
    chk("restart_p1", int'(player1_score), 0);
    chk("restart_p2", int'(player2_score), 0);
    cycle(0, 0, 512);
    cycle(1, 0, 512);
    chk("reserve_state", int'(state), 1);
    cycle(0, 0, 512);

    // Build 3:2 and stop mid-pause.
    goal(1020);
    goal(5);
    goal(1020);
    goal(5);
    cycle(0, 1, 1020);
    pause_ticks(30);
    chk("pre_rst_p1", int'(player1_score), 3);
    chk("pre_rst_p2", int'(player2_score), 2);
    chk("pre_rst_state", int'(state), 2);

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    cycle(0, 1, 5);
    chk("post_rst_state", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
